// File: rtl/alu_seq_if.sv
// Request/response and ALU-side bus of the alu_seq execution sequencer.
// slave = sequencer view, master = issuer + ALU view.
interface alu_seq_if #(
    parameter int DW = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_func2;
    logic [2:0]        req_func;
    logic [2*DW-1:0]   req_a;
    logic [2*DW-1:0]   req_b;
    logic              req_wide;
    logic              req_use_c;

    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic              alu_cin;
    logic [2:0]        alu_func;
    logic              alu_func2;
    logic [DW-1:0]     alu_out;
    logic              alu_c;
    logic              alu_z;
    logic              alu_v;
    logic              alu_s;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*DW-1:0]   rsp_data;

    logic              flag_c;
    logic              flag_z;
    logic              flag_v;
    logic              flag_s;

    modport slave (
        input  req_valid, req_func2, req_func, req_a, req_b, req_wide, req_use_c,
        output req_ready,
        output alu_a, alu_b, alu_cin, alu_func, alu_func2,
        input  alu_out, alu_c, alu_z, alu_v, alu_s,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output flag_c, flag_z, flag_v, flag_s
    );

    modport master (
        output req_valid, req_func2, req_func, req_a, req_b, req_wide, req_use_c,
        input  req_ready,
        input  alu_a, alu_b, alu_cin, alu_func, alu_func2,
        output alu_out, alu_c, alu_z, alu_v, alu_s,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  flag_c, flag_z, flag_v, flag_s
    );
endinterface

// File: rtl/alu_seq.sv
// Execution-stage sequencer: runs narrow ops in one ALU pass, wide ops in two chained passes.
// Optional flag write port enabled by defining PSW_WRITE_PORT_EN.
module alu_seq #(
    parameter int DW = 16
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef PSW_WRITE_PORT_EN
    input  logic       psw_we,
    input  logic [3:0] psw_wdata,
`endif
    alu_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state, state_next;

    logic            op_func2;
    logic [2:0]      op_func;
    logic [2*DW-1:0] op_a;
    logic [2*DW-1:0] op_b;
    logic            op_wide;
    logic            op_use_c;
    logic            carry_lo;
    logic            z_lo;
    logic [DW-1:0]   res_lo;
    logic [DW-1:0]   res_hi;
    logic [3:0]      flags;     // {c, z, v, s}

    logic            accept;
    logic            commit;
    logic            wide_eff;
    logic [3:0]      flags_new;

    // Only add/sub/logic codes chain across words; everything else runs narrow.
    assign wide_eff = bus.req_wide && !bus.req_func2 && (bus.req_func <= 3'b100);
    assign accept   = (state == IDLE) && bus.req_valid;
    assign commit   = ((state == LO) && !op_wide) || (state == HI);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_cin   = 1'b0;
        bus.alu_func  = 3'b111;
        bus.alu_func2 = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = LO;
            end
            LO: begin
                bus.alu_a     = op_a[DW-1:0];
                bus.alu_b     = op_b[DW-1:0];
                bus.alu_cin   = op_use_c & flags[3];
                bus.alu_func  = op_func;
                bus.alu_func2 = op_func2;
                state_next    = op_wide ? HI : RESP;
            end
            HI: begin
                bus.alu_a     = op_a[2*DW-1:DW];
                bus.alu_b     = op_b[2*DW-1:DW];
                bus.alu_cin   = carry_lo;
                bus.alu_func  = op_func;
                bus.alu_func2 = op_func2;
                state_next    = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Flags from the final pass; zero spans both words on a wide op, shifts never set C/V.
    always_comb begin
        flags_new[3] = bus.alu_c & ~op_func2;
        flags_new[2] = (state == HI) ? (z_lo & bus.alu_z) : bus.alu_z;
        flags_new[1] = bus.alu_v & ~op_func2;
        flags_new[0] = bus.alu_s;
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_func2 <= 1'b0;
            op_func  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_wide  <= 1'b0;
            op_use_c <= 1'b0;
            carry_lo <= 1'b0;
            z_lo     <= 1'b0;
            res_lo   <= '0;
            res_hi   <= '0;
            flags    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_func2 <= bus.req_func2;
                op_func  <= bus.req_func;
                op_a     <= bus.req_a;
                op_b     <= bus.req_b;
                op_wide  <= wide_eff;
                op_use_c <= bus.req_use_c;
            end
            if (state == LO) begin
                res_lo   <= bus.alu_out;
                res_hi   <= '0;
                carry_lo <= bus.alu_c;
                z_lo     <= bus.alu_z;
            end
            if (state == HI) res_hi <= bus.alu_out;
            if (commit) begin
                flags <= flags_new;
`ifdef PSW_WRITE_PORT_EN
            end else if (psw_we) begin
                flags <= psw_wdata;
`endif
            end
        end
    end

    assign bus.rsp_data = {res_hi, res_lo};
    assign bus.flag_c   = flags[3];
    assign bus.flag_z   = flags[2];
    assign bus.flag_v   = flags[1];
    assign bus.flag_s   = flags[0];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 16-bit ALU attached to the ALU side of the bus.
module tb_alu_seq;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    alu_seq_if #(.DW(16)) bus ();

`ifdef PSW_WRITE_PORT_EN
    logic       psw_we;
    logic [3:0] psw_wdata;
    alu_seq #(.DW(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .psw_we    (psw_we),
        .psw_wdata (psw_wdata),
        .bus       (bus)
    );
`else
    alu_seq #(.DW(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: result = b op a; sub carry is a borrow; rotate reports the wrapped bit as C.
    logic [16:0] alu_t;
    always_comb begin
        alu_t       = '0;
        bus.alu_out = '0;
        bus.alu_c   = 1'b0;
        bus.alu_v   = 1'b0;
        if (!bus.alu_func2) begin
            case (bus.alu_func)
                3'b000: begin
                    alu_t       = {1'b0, bus.alu_b} + {1'b0, bus.alu_a} + {16'd0, bus.alu_cin};
                    bus.alu_out = alu_t[15:0];
                    bus.alu_c   = alu_t[16];
                    bus.alu_v   = (bus.alu_a[15] == bus.alu_b[15]) && (alu_t[15] != bus.alu_b[15]);
                end
                3'b001: begin
                    alu_t       = {1'b0, bus.alu_b} - {1'b0, bus.alu_a} - {16'd0, bus.alu_cin};
                    bus.alu_out = alu_t[15:0];
                    bus.alu_c   = alu_t[16];
                    bus.alu_v   = (bus.alu_a[15] != bus.alu_b[15]) && (alu_t[15] != bus.alu_b[15]);
                end
                3'b010:  bus.alu_out = bus.alu_b & bus.alu_a;
                3'b011:  bus.alu_out = bus.alu_b | bus.alu_a;
                3'b100:  bus.alu_out = bus.alu_b ^ bus.alu_a;
                default: bus.alu_out = '0;
            endcase
        end else begin
            case (bus.alu_func)
                3'b000:  bus.alu_out = bus.alu_b << bus.alu_a[3:0];
                3'b001: begin
                    bus.alu_out = (bus.alu_b << bus.alu_a[3:0]) | (bus.alu_b >> (5'd16 - {1'b0, bus.alu_a[3:0]}));
                    bus.alu_c   = bus.alu_out[0];
                end
                3'b010:  bus.alu_out = bus.alu_b >> bus.alu_a[3:0];
                default: bus.alu_out = '0;
            endcase
        end
        bus.alu_z = (bus.alu_out == 16'd0);
        bus.alu_s = bus.alu_out[15];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
            $error("%s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.flag_c, bus.flag_z, bus.flag_v, bus.flag_s};
    endfunction

    task automatic drive_req(input logic f2, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic wide, input logic use_c);
        bus.req_valid = 1'b1;
        bus.req_func2 = f2;
        bus.req_func  = f;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_wide  = wide;
        bus.req_use_c = use_c;
    endtask

    // One full transaction with rsp_ready held high; lat counts the accept cycle as 1.
    task automatic do_op(input string tag, input logic f2, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic wide,
                         input logic use_c, input logic [31:0] exp_data,
                         input logic [3:0] exp_flags, input int exp_lat);
        int lat;
        check({tag, "/req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        drive_req(f2, f, a, b, wide, use_c);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check({tag, "/lo_alu_a"}, {16'd0, bus.alu_a}, {16'd0, a[15:0]});
        check({tag, "/lo_alu_b"}, {16'd0, bus.alu_b}, {16'd0, b[15:0]});
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/data"}, bus.rsp_data, exp_data);
        check({tag, "/flags"}, {28'd0, flags_now()}, {28'd0, exp_flags});
        @(posedge clk); #1;
        check({tag, "/idle"}, {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
    endtask

    initial begin
        int seen;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        bus.req_valid = 1'b0;
`ifdef PSW_WRITE_PORT_EN
        psw_we    = 1'b0;
        psw_wdata = 4'd0;
`endif
        #12;
        check("reset/req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset/rsp_data", bus.rsp_data, 32'd0);
        check("reset/flags", {28'd0, flags_now()}, 32'd0);
        check("reset/alu_ctl", {28'd0, bus.alu_func2, bus.alu_func}, 32'h7);
        check("reset/alu_ops", {bus.alu_a, bus.alu_b}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("wide_add", 1'b0, 3'b000, 32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010000, 4'b0000, 3);
        do_op("wide_sub", 1'b0, 3'b001, 32'h00000001, 32'h00010000, 1'b1, 1'b0, 32'h0000FFFF, 4'b0000, 3);
        do_op("preload_c", 1'b0, 3'b000, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b1100, 2);
        do_op("carry_in", 1'b0, 3'b000, 32'h00000001, 32'h00007FFF, 1'b0, 1'b1, 32'h00008001, 4'b0011, 2);
        do_op("rotate", 1'b1, 3'b001, 32'h00000004, 32'h00001234, 1'b1, 1'b0, 32'h00002341, 4'b0000, 2);
        do_op("unused_code", 1'b0, 3'b111, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'h00000000, 4'b0100, 2);
        do_op("wide_xor", 1'b0, 3'b100, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, 1'b0, 32'hF00FF00F, 4'b0001, 3);

        // Backpressure: response held for three cycles while another request waits.
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 3'b000, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_req(1'b0, 3'b000, 32'h00000002, 32'h00000003, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check("bp/rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp/data", bus.rsp_data, 32'd0);
            check("bp/flags", {28'd0, flags_now()}, {28'd0, 4'b1100});
            check("bp/req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp/release", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
        @(posedge clk); #1;
        check("bp/no_ghost", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);

        // Reset asserted during the high pass of a wide add.
        drive_req(1'b0, 3'b000, 32'h0000FFFF, 32'h00000001, 1'b1, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_hi/in_hi_cin", {31'd0, bus.alu_cin}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_hi/req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_hi/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_hi/rsp_data", bus.rsp_data, 32'd0);
        check("rst_hi/flags", {28'd0, flags_now()}, 32'd0);
        check("rst_hi/alu_func", {29'd0, bus.alu_func}, 32'h7);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        check("rst_hi/no_rsp", seen, 0);
        do_op("after_reset", 1'b0, 3'b000, 32'h00000010, 32'h00000020, 1'b0, 1'b1, 32'h00000030, 4'b0000, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
